// File: rtl/play_datapath_pkg.sv
// Shared encodings for the play controller and its datapath: outer/inner
// state codes, head direction codes and the default arena geometry.
package play_datapath_pkg;

    typedef enum logic [1:0] {
        O_S_WAIT = 2'd0,
        O_S_PLAY = 2'd1,
        O_S_END  = 2'd2
    } core_state_e;

    typedef enum logic [2:0] {
        I_S_INITIALIZE = 3'd0,
        I_S_READ_NEXT  = 3'd1,
        I_S_READ       = 3'd2,
        I_S_WRITE_HERE = 3'd3,
        I_S_NEXT_PIXEL = 3'd4
    } play_state_e;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_UP    = 2'd3
    } dir_e;

    localparam int unsigned ARENA_WIDTH       = 160;
    localparam int unsigned ARENA_HEIGHT      = 120;
    localparam int unsigned ARENA_FRAME_TICKS = 833333;
    localparam int unsigned ARENA_START_X     = 80;
    localparam int unsigned ARENA_START_Y     = 60;

    // Opposite directions differ only in the upper bit.
    function automatic dir_e reverse_dir(input dir_e d);
        return dir_e'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/play_datapath_frame_ticker.sv
// Free-running frame tick: counts enabled cycles and emits a registered
// one-cycle pulse every FRAME_TICKS cycles; held at zero while disabled.
module play_datapath_frame_ticker #(
    parameter int unsigned FRAME_TICKS = 833333
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        count_d = '0;
        tick_d  = 1'b0;
        if (enable) begin
            if (count_q == CNT_W'(FRAME_TICKS - 1)) begin
                tick_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/play_datapath.sv
// Game datapath: head position/direction, frame tick, arena clear sweep and
// the pixel RAM write port, sequenced by the outer/inner play controller.
module play_datapath
    import play_datapath_pkg::*;
#(
    parameter int unsigned       WIDTH       = ARENA_WIDTH,
    parameter int unsigned       HEIGHT      = ARENA_HEIGHT,
    parameter int unsigned       X_W         = 8,
    parameter int unsigned       Y_W         = 7,
    parameter int unsigned       ADDR_W      = 15,
    parameter int unsigned       COL_W       = 3,
    parameter int unsigned       FRAME_TICKS = ARENA_FRAME_TICKS,
    parameter int unsigned       START_X     = ARENA_START_X,
    parameter int unsigned       START_Y     = ARENA_START_Y,
    parameter logic [COL_W-1:0]  PLAYER_COL  = 3'b010,
    parameter logic [COL_W-1:0]  BG_COL      = 3'b000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        core_state,
    input  logic [2:0]        play_state,
    input  logic [1:0]        dir_in,
    input  logic [COL_W-1:0]  mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [COL_W-1:0]  mem_wdata,
    output logic              mem_we,
    output logic              sig_next_frame,
    output logic              sig_collision,
    output logic [X_W-1:0]    head_x,
    output logic [Y_W-1:0]    head_y
);

    core_state_e cs;
    play_state_e ps;
    assign cs = core_state_e'(core_state);
    assign ps = play_state_e'(play_state);

    logic [X_W-1:0]    head_x_q, head_x_d;
    logic [Y_W-1:0]    head_y_q, head_y_d;
    dir_e              dir_q, dir_d;
    logic              pending_q, pending_d;
    logic              wall_hit_q, wall_hit_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [COL_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              collision_q, collision_d;

    play_datapath_frame_ticker #(
        .FRAME_TICKS (FRAME_TICKS)
    ) u_frame_ticker (
        .clock  (clock),
        .reset  (reset),
        .enable (cs == O_S_PLAY),
        .tick   (sig_next_frame)
    );

    // One extra bit so stepping below 0 lands far above the limit (a wall).
    logic [X_W:0]      step_x;
    logic [Y_W:0]      step_y;
    logic              off_arena;
    logic [ADDR_W-1:0] head_addr;

    always_comb begin
        step_x = {1'b0, head_x_q};
        step_y = {1'b0, head_y_q};
        case (dir_q)
            DIR_RIGHT: step_x = {1'b0, head_x_q} + (X_W+1)'(1);
            DIR_DOWN:  step_y = {1'b0, head_y_q} + (Y_W+1)'(1);
            DIR_LEFT:  step_x = {1'b0, head_x_q} - (X_W+1)'(1);
            DIR_UP:    step_y = {1'b0, head_y_q} - (Y_W+1)'(1);
            default:   ;
        endcase
    end

    assign off_arena = (step_x >= (X_W+1)'(WIDTH)) || (step_y >= (Y_W+1)'(HEIGHT));
    assign head_addr = ADDR_W'(head_y_q) * ADDR_W'(WIDTH) + ADDR_W'(head_x_q);

    always_comb begin
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        dir_d       = dir_q;
        pending_d   = pending_q;
        wall_hit_d  = wall_hit_q;
        sweep_d     = sweep_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        collision_d = 1'b0;

        if (dir_e'(dir_in) != reverse_dir(dir_q)) begin
            dir_d = dir_e'(dir_in);
        end

        case (cs)
            O_S_WAIT: begin
                mem_we_d    = 1'b1;
                mem_wdata_d = BG_COL;
                mem_addr_d  = sweep_q;
                sweep_d     = (sweep_q == ADDR_W'(WIDTH * HEIGHT - 1)) ? '0 : sweep_q + ADDR_W'(1);
                head_x_d    = X_W'(START_X);
                head_y_d    = Y_W'(START_Y);
                dir_d       = DIR_RIGHT;
                wall_hit_d  = 1'b0;
                pending_d   = 1'b1;
            end
            O_S_PLAY: begin
                case (ps)
                    I_S_INITIALIZE: begin
                        if (off_arena) begin
                            wall_hit_d = 1'b1;
                        end else begin
                            head_x_d = step_x[X_W-1:0];
                            head_y_d = step_y[Y_W-1:0];
                        end
                        pending_d = 1'b1;
                    end
                    I_S_READ_NEXT: begin
                        mem_addr_d = head_addr;
                    end
                    I_S_WRITE_HERE: begin
                        // Only the first pass of a frame draws; mem_rdata is the head pixel.
                        if (pending_q) begin
                            if (wall_hit_q || (mem_rdata != BG_COL)) begin
                                collision_d = 1'b1;
                            end else begin
                                mem_we_d    = 1'b1;
                                mem_wdata_d = PLAYER_COL;
                            end
                            pending_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_x_q    <= X_W'(START_X);
            head_y_q    <= Y_W'(START_Y);
            dir_q       <= DIR_RIGHT;
            pending_q   <= 1'b1;
            wall_hit_q  <= 1'b0;
            sweep_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
            dir_q       <= dir_d;
            pending_q   <= pending_d;
            wall_hit_q  <= wall_hit_d;
            sweep_q     <= sweep_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            collision_q <= collision_d;
        end
    end

    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_we        = mem_we_q;
    assign sig_collision = collision_q;
    assign head_x        = head_x_q;
    assign head_y        = head_y_q;

endmodule

// File: tb/tb_play_datapath.sv
// Bench for play_datapath: acts as controller and pixel RAM, predicts writes,
// collisions and frame ticks from the game rules, and scoreboards them.
module tb_play_datapath;
    import play_datapath_pkg::*;

    localparam int FT    = 8;
    localparam int W     = 160;
    localparam int H     = 120;
    localparam int CELLS = W * H;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  core_state;
    logic [2:0]  play_state;
    logic [1:0]  dir_in;
    logic [2:0]  mem_rdata;
    logic [14:0] mem_addr;
    logic [2:0]  mem_wdata;
    logic        mem_we;
    logic        sig_next_frame;
    logic        sig_collision;
    logic [7:0]  head_x;
    logic [6:0]  head_y;

    play_datapath #(
        .FRAME_TICKS (FT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .core_state     (core_state),
        .play_state     (play_state),
        .dir_in         (dir_in),
        .mem_rdata      (mem_rdata),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .sig_next_frame (sig_next_frame),
        .sig_collision  (sig_collision),
        .head_x         (head_x),
        .head_y         (head_y)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Pixel RAM: synchronous read, one cycle latency.
    logic [2:0] ram [CELLS];
    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Frame model: a pulse after every FT consecutive PLAY cycles.
    int play_run  = 0;
    bit exp_frame = 1'b0;
    always @(posedge clock) begin
        exp_frame <= !reset && (core_state == O_S_PLAY) && (((play_run + 1) % FT) == 0);
        play_run  <= (reset || core_state != O_S_PLAY) ? 0 : play_run + 1;
    end

    typedef struct {
        bit is_write;
        int addr;
        int data;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    always @(negedge clock) begin
        check("next_frame", int'(sig_next_frame), int'(exp_frame));
        if (mem_we) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_write: got write addr=%0d data=%0d, expected no event", mem_addr, mem_wdata);
            end else begin
                mon_e = sb_q.pop_front();
                if (!mon_e.is_write || int'(mem_addr) != mon_e.addr || int'(mem_wdata) != mon_e.data) begin
                    n_fail++;
                    $display("FAIL sb_write: got write addr=%0d data=%0d, expected %s addr=%0d data=%0d",
                             mem_addr, mem_wdata, mon_e.is_write ? "write" : "collision", mon_e.addr, mon_e.data);
                end
            end
        end
        if (sig_collision) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_collision: got collision, expected no event");
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.is_write) begin
                    n_fail++;
                    $display("FAIL sb_collision: got collision, expected write addr=%0d data=%0d", mon_e.addr, mon_e.data);
                end
            end
        end
    end

    // Game-level reference state.
    int hx, hy, mdir, sweep_m;
    bit mwall;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_home();
        hx = 80; hy = 60; mdir = 0; mwall = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset  = 1'b1;
        dir_in = 2'd0;
        repeat (cycles) tick();
        model_home();
        sweep_m = 0;
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_mem_wdata", int'(mem_wdata), 0);
        check("rst_collision", int'(sig_collision), 0);
        check("rst_next_frame", int'(sig_next_frame), 0);
        check("rst_head_x", int'(head_x), 80);
        check("rst_head_y", int'(head_y), 60);
        reset = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        core_state = O_S_WAIT;
        dir_in     = 2'd0;
        model_home();
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{1'b1, sweep_m, 0});
            sweep_m = (sweep_m + 1) % CELLS;
            tick();
        end
    endtask

    task automatic idle_end(input int n);
        core_state = O_S_END;
        repeat (n) tick();
    endtask

    task automatic set_dir(input int d);
        dir_in = 2'(d);
        if (d != (mdir ^ 2)) mdir = d;
    endtask

    task automatic frame_pass(input int d, input bit extra_pass, output bit collided);
        int nx, ny, addr;
        core_state = O_S_PLAY;
        play_state = I_S_NEXT_PIXEL;
        set_dir(d);
        tick();
        nx = hx + ((mdir == 0) ? 1 : (mdir == 2) ? -1 : 0);
        ny = hy + ((mdir == 1) ? 1 : (mdir == 3) ? -1 : 0);
        if (nx < 0 || nx >= W || ny < 0 || ny >= H) mwall = 1'b1;
        else begin
            hx = nx;
            hy = ny;
        end
        play_state = I_S_INITIALIZE;
        tick();
        check("head_x", int'(head_x), hx);
        check("head_y", int'(head_y), hy);
        addr = hy * W + hx;
        play_state = I_S_READ_NEXT;
        tick();
        check("read_addr", int'(mem_addr), addr);
        collided = mwall || (ram[addr] != 3'b000);
        sb_q.push_back('{!collided, addr, 2});
        play_state = I_S_READ;       tick();
        play_state = I_S_WRITE_HERE; tick();
        play_state = I_S_NEXT_PIXEL; tick();
        if (extra_pass) begin
            play_state = I_S_READ_NEXT;  tick();
            play_state = I_S_READ;       tick();
            play_state = I_S_WRITE_HERE; tick();
            play_state = I_S_NEXT_PIXEL; tick();
        end
    endtask

    initial begin
        bit col;
        int pulses, nonzero;
        reset      = 1'b1;
        core_state = O_S_WAIT;
        play_state = I_S_INITIALIZE;
        dir_in     = 2'd0;
        do_reset(2);

        // Full clear sweep, then one more cycle to see the wrap to address 0.
        wait_cycles(CELLS);
        nonzero = 0;
        for (int i = 0; i < CELLS; i++) if (ram[i] != 3'b000) nonzero++;
        check("sweep_cleared_cells", nonzero, 0);
        wait_cycles(1);

        // Frame pulses over 40 idle PLAY cycles.
        core_state = O_S_PLAY;
        play_state = I_S_NEXT_PIXEL;
        pulses = 0;
        repeat (40) begin
            tick();
            if (sig_next_frame) pulses++;
        end
        check("frame_pulses_40", pulses, 5);

        // Clean move right onto (81,60) with a second idle pass.
        do_reset(1);
        frame_pass(0, 1'b1, col);
        check("clean_head_x", int'(head_x), 81);
        check("clean_addr", int'(mem_addr), 9681);
        check("clean_ram", int'(ram[9681]), 2);
        idle_end(3);

        // Trail hit on the pixel just drawn; reversal attempt still moves right.
        do_reset(1);
        frame_pass(0, 1'b0, col);
        idle_end(2);
        do_reset(1);
        frame_pass(2, 1'b0, col);
        check("reversal_head_x", int'(head_x), 81);
        idle_end(2);
        do_reset(1);
        frame_pass(1, 1'b0, col);
        frame_pass(3, 1'b1, col);
        check("reversal_head_y", int'(head_y), 62);
        idle_end(2);

        // Reset while WRITE_HERE is pending a collision on (80,61).
        do_reset(1);
        core_state = O_S_PLAY;
        set_dir(1);
        play_state = I_S_NEXT_PIXEL; tick();
        play_state = I_S_INITIALIZE; tick();
        play_state = I_S_READ_NEXT;  tick();
        play_state = I_S_READ;       tick();
        play_state = I_S_WRITE_HERE;
        do_reset(1);
        play_state = I_S_NEXT_PIXEL;
        idle_end(3);

        // Wall: climb to row 10, run right to column 159, then hit the wall.
        wait_cycles(5);
        for (int i = 0; i < 50; i++) frame_pass(3, 1'b0, col);
        for (int i = 0; i < 79; i++) frame_pass(0, 1'b0, col);
        check("pre_wall_head_x", int'(head_x), 159);
        frame_pass(0, 1'b0, col);
        check("wall_head_x", int'(head_x), 159);
        check("wall_head_y", int'(head_y), 10);
        idle_end(5);

        // Random games on a partially cleared arena.
        for (int g = 0; g < 6; g++) begin
            wait_cycles(int'($urandom_range(3, 40)));
            for (int f = 0; f < 80; f++) begin
                frame_pass(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), col);
                if (col) break;
            end
            idle_end(3);
        end

        idle_end(4);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/play_datapath.md
Name: play_datapath

Overview:
- Datapath counterpart to the game's outer/inner play controller.
- Consumes core_state/play_state from the controller and produces the two status signals the controller sequences on: sig_next_frame (frame tick) and sig_collision (head hit trail or wall).
- Owns the player head position and direction, the frame tick counter, the arena-clear sweep, and the write port to the arena pixel RAM, which the VGA adapter also displays.

Parameters:
- WIDTH, 160, arena columns.
- HEIGHT, 120, arena rows.
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- ADDR_W, 15, RAM address width; address = y*WIDTH + x.
- COL_W, 3, pixel colour width.
- FRAME_TICKS, 833333, clock cycles per game frame.
- START_X, 80, start column.
- START_Y, 60, start row.
- PLAYER_COL, 3'b010, trail colour.
- BG_COL, 3'b000, background colour.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- core_state  in  2  outer state: 0 WAIT, 1 PLAY, 2 END.
- play_state  in  3  inner state: 0 INITIALIZE, 1 READ_NEXT, 2 READ, 3 WRITE_HERE, 4 NEXT_PIXEL.
- dir_in  in  2  requested direction: 0 right, 1 down, 2 left, 3 up.
- mem_rdata  in  COL_W  RAM read data; synchronous RAM, 1-cycle latency.
- mem_addr  out  ADDR_W  RAM address, registered.
- mem_wdata  out  COL_W  RAM write data, registered.
- mem_we  out  1  RAM write enable, registered.
- sig_next_frame  out  1  one-cycle frame pulse, registered.
- sig_collision  out  1  one-cycle collision pulse, registered.
- head_x  out  X_W  current head column.
- head_y  out  Y_W  current head row.

Behaviour:
- Reset (sync, high):
  - head=(START_X,START_Y), dir=0.
  - Frame counter=0; sweep address=0.
  - pending=1, wall_hit=0.
  - All outputs 0 except head_x/head_y.
  - Reset dominates every other condition, including mid-frame and mid-sweep.
- Frame counter:
  - Increments only while core_state==PLAY; held at 0 otherwise.
  - Registered sig_next_frame=1 is presented for the single cycle after the counter reaches FRAME_TICKS-1; counter then wraps to 0.
- Direction: each cycle, dir_in is latched into dir unless it equals the reverse of the current dir (dir XOR 2). Reversals are ignored.
- INITIALIZE (entered after each frame pulse):
  - Compute next = head + step(dir).
  - If next would leave [0,WIDTH-1]x[0,HEIGHT-1]: wall_hit<=1 and head is unchanged.
  - Otherwise head<=next.
  - pending<=1.
- READ_NEXT: mem_addr<=head_y*WIDTH+head_x.
- READ: RAM registers the address; no datapath action.
- WRITE_HERE, when pending:
  - Evaluate mem_rdata (valid this cycle).
  - If wall_hit or mem_rdata!=BG_COL: sig_collision<=1 for one cycle; no write.
  - Else mem_we<=1 and mem_wdata<=PLAYER_COL for one cycle, with mem_addr held.
  - pending<=0.
- WRITE_HERE when pending==0: no action. Later passes of the inner loop in the same frame are idle.
- NEXT_PIXEL: no action; mem_we drops.
- Simultaneous frame pulse and collision: both pulses are emitted. Collision takes priority in the controller, which enters END.
- END: frame counter is frozen at 0; no writes; head is held so it stays visible.
- WAIT, clear sweep:
  - Each cycle mem_we=1, mem_wdata=BG_COL, mem_addr=sweep.
  - sweep increments and wraps to 0 after WIDTH*HEIGHT-1.
  - head=(START_X,START_Y), dir=0, wall_hit=0, pending=1.
  - On leaving WAIT, sweep holds its value. A partially cleared arena is acceptable because the press timing of key_start is user-controlled.
- Width rules:
  - Address multiply is unsigned, ADDR_W bits.
  - Step arithmetic uses X_W+1 / Y_W+1 bits so that an underflow at 0 is detected as a wall, not a wrap.

Decomposition:
- Shared include game_states.vh holds the O_S_* and I_S_* encodings, used by both the controller and this block, plus the direction encodings.
- Sub-module frame_ticker: parameter FRAME_TICKS; inputs clock, reset, enable; output tick.

Test Plan:
- Frame tick, FRAME_TICKS=8: hold PLAY for 40 cycles → sig_next_frame pulses every 8 cycles, each 1 cycle wide; in WAIT, no pulses.
- Clean move: PLAY, dir_in=0, RAM all BG; drive one inner pass → head (80,60)→(81,60); mem_addr=60*160+81=9681; mem_we pulses once with wdata=3'b010.
- Trail hit: RAM[9681]=3'b010, head (80,60), dir right → sig_collision=1 for one cycle; mem_we stays 0.
- Wall and reversal:
  - head (159,10), dir right, frame → wall_hit; sig_collision in WRITE_HERE; head stays (159,10).
  - dir_in=2 while dir=0 → dir stays 0.
- Clear sweep: WAIT for 19200 cycles → every address 0..19199 is written with BG_COL once, then the sweep wraps to 0.
- Mid-operation reset: assert reset in WRITE_HERE with pending=1 → next cycle all outputs 0, head=(80,60), no write or collision emitted.
